vram_port_arbiter: RTL and testbench

- Shares one single-port synchronous VRAM between the display fetch path (transformer address/enable) and a game-logic writer that updates artwork/tiles at run time.
- Display reads have absolute priority. Writer requests are buffered in a small FIFO and drained only in cycles where the display is not reading, i.e. blanking or off-layer pixels.
- Sits between a transformer/vram pair in the video top level. Replaces the direct transformer-to-vram hookup for any layer that needs run-time writes.

---
 rtl/vram_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// vram_port_arbiter
//
// Purpose:
//   Shares one single-port synchronous VRAM between the display fetch path
//   and a run-time game-logic writer. Display reads always win the port.
//   Writer requests are queued in a small FIFO. The FIFO is drained only in
//   cycles where the display is not reading (blanking or off-layer pixels).
//
// Optional feature macro: ARB_STALL_CNT_EN
//   Defined   : stall_cycles counts cycles spent in HOLD and saturates at
//               16'hFFFF. Only rst clears it.
//   Undefined : stall_cycles is tied to zero and no counter is built.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   disp_en       display read request (transformer valid)
//   disp_addr     display read address
//   disp_data     read data, valid the cycle after disp_en
//   wr_valid      writer request valid
//   wr_ready      FIFO can accept a write
//   wr_addr       writer address
//   wr_data       writer data
//   ram_en        VRAM enable
//   ram_we        VRAM write enable
//   ram_addr      VRAM address
//   ram_wdata     VRAM write data
//   ram_rdata     VRAM read data (1-cycle synchronous)
//   fifo_count    number of buffered writes
//   busy          FIFO non-empty (FSM not IDLE)
//   stall_cycles  cycles the writer was held off (see macro above)
// ---------------------------------------------------------------------------
module vram_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_en,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic [DATA_W-1:0]             disp_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic [15:0]                   stall_cycles
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // FIFO storage: the head is read combinationally so it can be presented
  // to the RAM in the same cycle that it pops.
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;

  logic push;
  logic pop;
  logic fifo_nonempty;

  assign fifo_nonempty = (count_q != CNT_ZERO);

  // wr_ready depends only on the registered count. A full FIFO therefore
  // refuses a write even in a cycle where it also pops.
  assign wr_ready = (count_q != CNT_FULL);
  assign push     = wr_valid && wr_ready;
  assign pop      = !disp_en && fifo_nonempty;

  // ---------------------------------------------------------------------
  // Port mux: display read > buffered write > idle
  // ---------------------------------------------------------------------
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (disp_en) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (fifo_nonempty) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = addr_mem[rd_ptr_q];
      ram_wdata = data_mem[rd_ptr_q];
    end
  end

  // The read data is a plain passthrough, so the read latency is the same
  // as for a directly attached VRAM.
  assign disp_data = ram_rdata;

  // ---------------------------------------------------------------------
  // FIFO pointers and count
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr;
      data_mem[wr_ptr_q] <= wr_data;
    end
  end

  assign fifo_count = count_q;

  // ---------------------------------------------------------------------
  // FSM: the next state is re-derived every cycle from the post-edge
  // occupancy and the current display request.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (count_d == CNT_ZERO) begin
      state_d = IDLE;
    end else if (disp_en) begin
      state_d = HOLD;
    end else begin
      state_d = DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Optional writer-stall counter
  // ---------------------------------------------------------------------
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'h0000;
    end else if ((state_q == HOLD) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_port_arbiter
//
// Directed bench for vram_port_arbiter. It contains a behavioural VRAM and
// a queue-based reference model. The reference model says that display
// reads always win. Otherwise the oldest queued write goes to the RAM.
// Writes are accepted while fewer than FIFO_DEPTH are queued. A compare
// process checks every output on each falling edge. Directed steps add
// literal, hand-worked expectations.
// ---------------------------------------------------------------------------
module tb_vram_port_arbiter;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 13;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_en;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [2:0]        fifo_count;
  logic              busy;
  logic [15:0]       stall_cycles;

  int passed = 0;
  int total  = 0;

  vram_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_en     (disp_en),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous VRAM.
  logic [DATA_W-1:0] vmem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) vmem[ram_addr] <= ram_wdata;
      else        ram_rdata      <= vmem[ram_addr];
    end
  end

  // Reference model.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               q[$];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_rdata = '0;
  logic [15:0]       exp_stall = '0;
  logic              last_disp = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_stall = 16'h0000;
      last_disp = 1'b0;
    end else begin
      int  sz;
      bit  acc;
      sz  = q.size();
      acc = wr_valid && (sz != FIFO_DEPTH);
`ifdef ARB_STALL_CNT_EN
      // The writer was held through this cycle when data waited and the
      // display owned the port in the previous cycle.
      if (sz != 0 && last_disp && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
      if (disp_en) begin
        exp_rdata = shadow[disp_addr];
      end else if (sz != 0) begin
        shadow[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (acc) q.push_back('{a: wr_addr, d: wr_data});
      last_disp = disp_en;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit          ne;
    logic [ADDR_W-1:0] ea;
    ne = (q.size() != 0);
    ea = disp_en ? disp_addr : (ne ? q[0].a : '0);
    chk("ram_en",     32'(ram_en),     32'(disp_en || ne));
    chk("ram_we",     32'(ram_we),     32'(!disp_en && ne));
    chk("ram_addr",   32'(ram_addr),   32'(ea));
    if (!disp_en && ne) chk("ram_wdata", 32'(ram_wdata), 32'(q[0].d));
    chk("wr_ready",   32'(wr_ready),   32'(q.size() != FIFO_DEPTH));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("busy",       32'(busy),       32'(ne));
    chk("stall",      32'(stall_cycles), 32'(exp_stall));
    chk("disp_data",  32'(disp_data),  32'(exp_rdata));
  end

  // Drive phase: 1 time unit after the rising edge. The look phase then
  // follows 2 more units later, before the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic idle_inputs();
    disp_en   = 1'b0;
    disp_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) begin
      vmem[i]   = '0;
      shadow[i] = '0;
    end
    vmem[5]   = 13'h0F0F;
    shadow[5] = 13'h0F0F;
    ram_rdata = '0;
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state.
    look();
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_en",    32'(ram_en), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    step();

    // Read priority over a concurrent write.
    disp_en = 1'b1; disp_addr = 15'h0123;
    wr_valid = 1'b1; wr_addr = 15'h0200; wr_data = 13'h1ABC;
    look();
    chk("prio_we",   32'(ram_we), 32'd0);
    chk("prio_addr", 32'(ram_addr), 32'h0123);
    step();
    wr_valid = 1'b0;
    look();
    chk("prio_count", 32'(fifo_count), 32'd1);
    chk("prio_we2",   32'(ram_we), 32'd0);
    step();
    disp_en = 1'b0;
    look();
    chk("drain_we",    32'(ram_we), 32'd1);
    chk("drain_addr",  32'(ram_addr), 32'h0200);
    chk("drain_wdata", 32'(ram_wdata), 32'h1ABC);
    step();
    look();
    chk("drain_empty", 32'(fifo_count), 32'd0);

    // Read latency, preloaded word and freshly written word.
    step();
    disp_en = 1'b1; disp_addr = 15'h0005;
    step();
    disp_en = 1'b0;
    look();
    chk("lat_0005", 32'(disp_data), 32'h0F0F);
    step();
    disp_en = 1'b1; disp_addr = 15'h0200;
    step();
    disp_en = 1'b0;
    look();
    chk("lat_0200", 32'(disp_data), 32'h1ABC);
    step();

    // Full backpressure.
    disp_en = 1'b1; disp_addr = 15'h0010;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 15'(16'h0300 + i); wr_data = 13'(16'h0100 + i);
      step();
    end
    wr_addr = 15'h03FF; wr_data = 13'h1FFF;
    look();
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(wr_ready), 32'd0);
    step();
    look();
    chk("full_5th", 32'(fifo_count), 32'd4);
    step();
    disp_en = 1'b0;  // 5th request still presented while the first pop happens
    look();
    chk("nofill_ready", 32'(wr_ready), 32'd0);
    chk("bp_addr0", 32'(ram_addr), 32'h0300);
    step();
    wr_valid = 1'b0;
    look();
    chk("nofill_count", 32'(fifo_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("bp_addr", 32'(ram_addr), 32'(16'h0300 + i));
      step();
      look();
    end
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_en",   32'(ram_en), 32'd0);
    step();

    // Simultaneous push and pop.
    disp_en = 1'b1; disp_addr = 15'h0011;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = 15'(16'h0400 + i); wr_data = 13'(16'h0040 + i);
      step();
    end
    disp_en = 1'b0;
    for (int i = 2; i < 4; i++) begin
      wr_addr = 15'(16'h0400 + i); wr_data = 13'(16'h0040 + i);
      step();
    end
    wr_valid = 1'b0;
    look();
    chk("pp_count", 32'(fifo_count), 32'd2);
    chk("pp_head",  32'(ram_addr), 32'h0402);
    step();
    step();
    look();
    chk("pp_done", 32'(fifo_count), 32'd0);
    step();

    // Stall counter: one buffered write, display busy for 10 cycles.
    disp_en = 1'b1; disp_addr = 15'h0020;
    wr_valid = 1'b1; wr_addr = 15'h0500; wr_data = 13'h0555;
    step();
    wr_valid = 1'b0;
    repeat (9) step();
    disp_en = 1'b0;
    step();
    look();
`ifdef ARB_STALL_CNT_EN
    chk("stall_10", 32'(stall_cycles), 32'd10);
`else
    chk("stall_10", 32'(stall_cycles), 32'd0);
`endif
    step();
`ifdef ARB_STALL_CNT_EN
    disp_en = 1'b1;
    wr_valid = 1'b1; wr_addr = 15'h0501; wr_data = 13'h0666;
    step();
    wr_valid = 1'b0;
    repeat (70000) step();
    look();
    chk("stall_sat", 32'(stall_cycles), 32'hFFFF);
    disp_en = 1'b0;
    repeat (2) step();
`endif

    // Asynchronous reset while draining with 3 entries buffered.
    disp_en = 1'b1; disp_addr = 15'h0030;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 15'(16'h0600 + i); wr_data = 13'(16'h0060 + i);
      step();
    end
    wr_valid = 1'b0; disp_en = 1'b0;
    look();
    chk("pre_rst_we", 32'(ram_we), 32'd1);
    chk("pre_rst_cnt", 32'(fifo_count), 32'd3);
    step();
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_we",    32'(ram_we), 32'd0);
    chk("arst_ready", 32'(wr_ready), 32'd1);
    step();
    rst = 1'b0;
    repeat (5) step();
    look();
    chk("post_rst_en", 32'(ram_en), 32'd0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
